// File: rtl/smc_frame_loader_if.sv
// smc_frame_loader_if: bundles every signal between the frame loader, its
// upstream beat source, the SMC stage it feeds and the result consumer.
//   beat stream : in_valid, in_ready, mode_in, w_in, vgs_in, vds_in
//   SMC drive   : W_0..W_5, V_GS_0..V_GS_5, V_DS_0..V_DS_5, mode
//   SMC return  : smc_out (SMC out_n)
//   result      : out_valid, out_data
// master = environment side (source/SMC/consumer), slave = the loader.
`timescale 1ns/1ps
interface smc_frame_loader_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] mode_in;
  logic [2:0] w_in, vgs_in, vds_in;
  logic [2:0] W_0, W_1, W_2, W_3, W_4, W_5;
  logic [2:0] V_GS_0, V_GS_1, V_GS_2, V_GS_3, V_GS_4, V_GS_5;
  logic [2:0] V_DS_0, V_DS_1, V_DS_2, V_DS_3, V_DS_4, V_DS_5;
  logic [1:0] mode;
  logic [9:0] smc_out;
  logic       out_valid;
  logic [9:0] out_data;

  modport master (
    output in_valid, mode_in, w_in, vgs_in, vds_in, smc_out,
    input  in_ready, mode, out_valid, out_data,
    input  W_0, W_1, W_2, W_3, W_4, W_5,
    input  V_GS_0, V_GS_1, V_GS_2, V_GS_3, V_GS_4, V_GS_5,
    input  V_DS_0, V_DS_1, V_DS_2, V_DS_3, V_DS_4, V_DS_5
  );

  modport slave (
    input  in_valid, mode_in, w_in, vgs_in, vds_in, smc_out,
    output in_ready, mode, out_valid, out_data,
    output W_0, W_1, W_2, W_3, W_4, W_5,
    output V_GS_0, V_GS_1, V_GS_2, V_GS_3, V_GS_4, V_GS_5,
    output V_DS_0, V_DS_1, V_DS_2, V_DS_3, V_DS_4, V_DS_5
  );
endinterface

// File: rtl/smc_frame_loader.sv
// smc_frame_loader: collects six serial transistor beats (W, V_GS, V_DS) into
// parallel slots plus a frame mode, holds them stable for EVAL_CYCLES while
// the combinational SMC stage settles, then captures SMC out_n into out_data
// and pulses out_valid for one cycle.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - smc_frame_loader_if.slave (beat stream, SMC drive/return, result)
// Parameter EVAL_CYCLES: settle window in cycles, legal 1..4.
`timescale 1ns/1ps

// One parallel slot: loads a beat when its write enable fires, else holds.
module smc_frame_slot (
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [2:0] w_d,
  input  logic [2:0] g_d,
  input  logic [2:0] d_d,
  output logic [2:0] w_q,
  output logic [2:0] g_q,
  output logic [2:0] d_q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q <= '0;
      g_q <= '0;
      d_q <= '0;
    end else if (we) begin
      w_q <= w_d;
      g_q <= g_d;
      d_q <= d_d;
    end
  end
endmodule

module smc_frame_loader #(
  parameter int EVAL_CYCLES = 1
) (
  input logic              clk,
  input logic              rst,
  smc_frame_loader_if.slave bus
);
  localparam int NUM_SLOTS = 6;

  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] EVAL    = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  localparam logic [1:0] EVAL_LAST = 2'(EVAL_CYCLES - 1);

  logic [1:0]                      state;
  logic [2:0]                      cnt;
  logic [1:0]                      eval_cnt;
  logic                            accept;
  logic [NUM_SLOTS-1:0]            we;
  logic [NUM_SLOTS-1:0][2:0]       w_q, g_q, d_q;
  logic [1:0]                      mode_q;
  logic [9:0]                      out_q;

  // Ready and result pulse are pure state decodes, so reset kills them
  // immediately without waiting for a clock.
  assign bus.in_ready  = (state == COLLECT);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = out_q;
  assign bus.mode      = mode_q;
  assign accept        = bus.in_valid && (state == COLLECT);

  generate
    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      assign we[i] = accept && (cnt == 3'(i));
      smc_frame_slot u_slot (
        .clk (clk),
        .rst (rst),
        .we  (we[i]),
        .w_d (bus.w_in),
        .g_d (bus.vgs_in),
        .d_d (bus.vds_in),
        .w_q (w_q[i]),
        .g_q (g_q[i]),
        .d_q (d_q[i])
      );
    end
  endgenerate

  // Frame control: slots and mode only move on accepted beats, which keeps
  // every SMC input frozen for the whole EVAL window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= COLLECT;
      cnt      <= '0;
      eval_cnt <= '0;
      mode_q   <= '0;
      out_q    <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            if (cnt == 3'd0) mode_q <= bus.mode_in;
            if (cnt == 3'(NUM_SLOTS - 1)) begin
              cnt      <= '0;
              eval_cnt <= '0;
              state    <= EVAL;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        EVAL: begin
          if (eval_cnt == EVAL_LAST) begin
            out_q    <= bus.smc_out;
            eval_cnt <= '0;
            state    <= DONE;
          end else begin
            eval_cnt <= eval_cnt + 2'd1;
          end
        end
        DONE:    state <= COLLECT;
        default: state <= COLLECT;
      endcase
    end
  end

  assign bus.W_0 = w_q[0];  assign bus.V_GS_0 = g_q[0];  assign bus.V_DS_0 = d_q[0];
  assign bus.W_1 = w_q[1];  assign bus.V_GS_1 = g_q[1];  assign bus.V_DS_1 = d_q[1];
  assign bus.W_2 = w_q[2];  assign bus.V_GS_2 = g_q[2];  assign bus.V_DS_2 = d_q[2];
  assign bus.W_3 = w_q[3];  assign bus.V_GS_3 = g_q[3];  assign bus.V_DS_3 = d_q[3];
  assign bus.W_4 = w_q[4];  assign bus.V_GS_4 = g_q[4];  assign bus.V_DS_4 = d_q[4];
  assign bus.W_5 = w_q[5];  assign bus.V_GS_5 = g_q[5];  assign bus.V_DS_5 = d_q[5];
endmodule

// File: tb/tb_smc_frame_loader.sv
// Directed bench for smc_frame_loader (EVAL_CYCLES=1 and EVAL_CYCLES=4 builds).
// A small stand-in for SMC returns mode*100 + sum of all slot fields, so the
// captured result depends on every slot and on the frame mode.
`timescale 1ns/1ps
module tb_smc_frame_loader;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  smc_frame_loader_if bus1();
  smc_frame_loader_if bus4();

  smc_frame_loader #(.EVAL_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  smc_frame_loader #(.EVAL_CYCLES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  function automatic logic [9:0] smc_stub(input logic [17:0] w, input logic [17:0] g,
                                          input logic [17:0] d, input logic [1:0] m);
    logic [9:0] s;
    s = 10'(m) * 10'd100;
    for (int i = 0; i < 6; i++)
      s = s + 10'(w[3*i +: 3]) + 10'(g[3*i +: 3]) + 10'(d[3*i +: 3]);
    return s;
  endfunction

  assign bus1.smc_out = smc_stub({bus1.W_5, bus1.W_4, bus1.W_3, bus1.W_2, bus1.W_1, bus1.W_0},
    {bus1.V_GS_5, bus1.V_GS_4, bus1.V_GS_3, bus1.V_GS_2, bus1.V_GS_1, bus1.V_GS_0},
    {bus1.V_DS_5, bus1.V_DS_4, bus1.V_DS_3, bus1.V_DS_2, bus1.V_DS_1, bus1.V_DS_0}, bus1.mode);
  assign bus4.smc_out = smc_stub({bus4.W_5, bus4.W_4, bus4.W_3, bus4.W_2, bus4.W_1, bus4.W_0},
    {bus4.V_GS_5, bus4.V_GS_4, bus4.V_GS_3, bus4.V_GS_2, bus4.V_GS_1, bus4.V_GS_0},
    {bus4.V_DS_5, bus4.V_DS_4, bus4.V_DS_3, bus4.V_DS_2, bus4.V_DS_1, bus4.V_DS_0}, bus4.mode);

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one beat on bus1 after 'gap' idle cycles and hold it until accepted.
  task automatic beat(input logic [1:0] m, input logic [2:0] w, input logic [2:0] g,
                      input logic [2:0] d, input int gap);
    int n;
    bus1.in_valid = 0;
    repeat (gap) step();
    bus1.mode_in = m;
    bus1.w_in = w;
    bus1.vgs_in = g;
    bus1.vds_in = d;
    bus1.in_valid = 1;
    n = 0;
    while (!bus1.in_ready && n < 20) begin
      step();
      n++;
    end
    chk("beat_ready", 32'(bus1.in_ready), 32'd1);
    step();
    bus1.in_valid = 0;
  endtask

  // Called just after the 6th beat's edge: measure result latency and pulse width.
  task automatic wait_result(input string tag, input int exp_lat, input logic [9:0] exp_data);
    int n;
    n = 0;
    while (!bus1.out_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk({tag, "_data"}, 32'(bus1.out_data), 32'(exp_data));
    step();
    chk({tag, "_pulse_width"}, 32'(bus1.out_valid), 32'd0);
  endtask

  task automatic uniform_frame(input logic [1:0] m);
    for (int i = 0; i < 6; i++) beat(m, 3'd3, 3'd3, 3'd3, 0);
  endtask

  initial begin
    logic [2:0] mw[6], mg[6], md[6];
    logic [1:0] mm[6];
    int gaps[6];
    int acc, pulses, rdy_low, first_p, last_p, gap_ok, n;
    logic [55:0] snap;
    logic changed;

    rst = 1;
    bus1.in_valid = 0; bus1.mode_in = 0; bus1.w_in = 0; bus1.vgs_in = 0; bus1.vds_in = 0;
    bus4.in_valid = 0; bus4.mode_in = 0; bus4.w_in = 0; bus4.vgs_in = 0; bus4.vds_in = 0;

    // Reset state
    #2;
    chk("rst_in_ready", 32'(bus1.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus1.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus1.out_data), 32'd0);
    chk("rst_mode", 32'(bus1.mode), 32'd0);
    chk("rst_w_slots", 32'({bus1.W_5, bus1.W_4, bus1.W_3, bus1.W_2, bus1.W_1, bus1.W_0}), 32'd0);
    #10 rst = 0;
    step();
    chk("idle_in_ready", 32'(bus1.in_ready), 32'd1);
    chk("idle_out_valid", 32'(bus1.out_valid), 32'd0);

    // Uniform frames: 3/3/3 everywhere -> 54 plus mode*100
    uniform_frame(2'b11);
    chk("u3_mode", 32'(bus1.mode), 32'd3);
    wait_result("u3", 1, 10'd354);
    uniform_frame(2'b00);
    wait_result("u0", 1, 10'd54);

    // Mixed frame with stalls and mode_in toggling after beat 0
    mw = '{3'd7, 3'd7, 3'd7, 3'd3, 3'd3, 3'd3};
    mg = '{3'd7, 3'd7, 3'd7, 3'd3, 3'd3, 3'd3};
    md = '{3'd1, 3'd1, 3'd1, 3'd3, 3'd3, 3'd3};
    mm = '{2'd2, 2'd1, 2'd3, 2'd0, 2'd3, 2'd1};
    gaps = '{0, 2, 1, 0, 3, 1};
    for (int i = 0; i < 6; i++) beat(mm[i], mw[i], mg[i], md[i], gaps[i]);
    chk("mix_mode", 32'(bus1.mode), 32'd2);
    chk("mix_w_order", 32'({bus1.W_5, bus1.W_4, bus1.W_3, bus1.W_2, bus1.W_1, bus1.W_0}),
        32'({3'd3, 3'd3, 3'd3, 3'd7, 3'd7, 3'd7}));
    chk("mix_vds_order", 32'({bus1.V_DS_5, bus1.V_DS_4, bus1.V_DS_3, bus1.V_DS_2, bus1.V_DS_1, bus1.V_DS_0}),
        32'({3'd3, 3'd3, 3'd3, 3'd1, 3'd1, 3'd1}));
    wait_result("mix", 1, 10'd272);

    // Distinct per-slot values: W=i, V_GS=7-i, V_DS=i+1, mode 1 -> 63+100
    for (int i = 0; i < 6; i++) beat(2'd1, 3'(i), 3'(7 - i), 3'(i + 1), 0);
    chk("dst_w", 32'({bus1.W_5, bus1.W_4, bus1.W_3, bus1.W_2, bus1.W_1, bus1.W_0}),
        32'({3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}));
    chk("dst_vgs", 32'({bus1.V_GS_5, bus1.V_GS_4, bus1.V_GS_3, bus1.V_GS_2, bus1.V_GS_1, bus1.V_GS_0}),
        32'({3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}));
    chk("dst_vds", 32'({bus1.V_DS_5, bus1.V_DS_4, bus1.V_DS_3, bus1.V_DS_2, bus1.V_DS_1, bus1.V_DS_0}),
        32'({3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}));
    wait_result("dst", 1, 10'd163);

    // Back-pressure: in_valid held high for 3 frames (24 cycles)
    bus1.mode_in = 2'b11; bus1.w_in = 3'd3; bus1.vgs_in = 3'd3; bus1.vds_in = 3'd3;
    bus1.in_valid = 1;
    acc = 0; pulses = 0; rdy_low = 0; first_p = -1; last_p = -1; gap_ok = 1;
    for (int c = 0; c < 24; c++) begin
      if (bus1.in_ready) acc++; else rdy_low++;
      if (bus1.out_valid) begin
        pulses++;
        if (last_p >= 0 && c - last_p != 8) gap_ok = 0;
        if (first_p < 0) first_p = c;
        last_p = c;
        if (bus1.out_data !== 10'd354) gap_ok = 0;
      end
      if (c == 23) bus1.in_valid = 0;
      step();
    end
    chk("bp_beats", 32'(acc), 32'd18);
    chk("bp_ready_low", 32'(rdy_low), 32'd6);
    chk("bp_pulses", 32'(pulses), 32'd3);
    chk("bp_first_pulse", 32'(first_p), 32'd7);
    chk("bp_spacing_data", 32'(gap_ok), 32'd1);

    // Reset mid-frame: 4 beats, async reset, then a clean frame
    for (int i = 0; i < 4; i++) beat(2'd1, 3'd7, 3'd1, 3'd2, 0);
    #2 rst = 1;
    #1;
    chk("mid_rst_in_ready", 32'(bus1.in_ready), 32'd1);
    chk("mid_rst_out_data", 32'(bus1.out_data), 32'd0);
    chk("mid_rst_mode", 32'(bus1.mode), 32'd0);
    chk("mid_rst_w_slots", 32'({bus1.W_5, bus1.W_4, bus1.W_3, bus1.W_2, bus1.W_1, bus1.W_0}), 32'd0);
    #2 rst = 0;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus1.out_valid) pulses++;
    end
    chk("mid_rst_no_pulse", 32'(pulses), 32'd0);
    uniform_frame(2'b11);
    wait_result("post_rst", 1, 10'd354);

    // EVAL_CYCLES=4 build; in_valid held with new data during EVAL/DONE
    bus4.mode_in = 2'b11; bus4.w_in = 3'd3; bus4.vgs_in = 3'd3; bus4.vds_in = 3'd3;
    bus4.in_valid = 1;
    repeat (6) step();
    snap = {bus4.W_5, bus4.W_4, bus4.W_3, bus4.W_2, bus4.W_1, bus4.W_0,
            bus4.V_GS_5, bus4.V_GS_4, bus4.V_GS_3, bus4.V_GS_2, bus4.V_GS_1, bus4.V_GS_0,
            bus4.V_DS_5, bus4.V_DS_4, bus4.V_DS_3, bus4.V_DS_2, bus4.V_DS_1, bus4.V_DS_0, bus4.mode};
    bus4.w_in = 3'd5; bus4.vgs_in = 3'd5; bus4.vds_in = 3'd5; bus4.mode_in = 2'b01;
    n = 0; rdy_low = 0; changed = 0;
    while (!bus4.out_valid && n < 20) begin
      if (!bus4.in_ready) rdy_low++;
      if (snap !== {bus4.W_5, bus4.W_4, bus4.W_3, bus4.W_2, bus4.W_1, bus4.W_0,
            bus4.V_GS_5, bus4.V_GS_4, bus4.V_GS_3, bus4.V_GS_2, bus4.V_GS_1, bus4.V_GS_0,
            bus4.V_DS_5, bus4.V_DS_4, bus4.V_DS_3, bus4.V_DS_2, bus4.V_DS_1, bus4.V_DS_0, bus4.mode})
        changed = 1;
      step();
      n++;
    end
    if (!bus4.in_ready) rdy_low++;
    chk("e4_lat", 32'(n), 32'd4);
    chk("e4_data", 32'(bus4.out_data), 32'd354);
    chk("e4_inputs_stable", 32'(changed), 32'd0);
    step();
    chk("e4_ready_low", 32'(rdy_low), 32'd5);
    chk("e4_ready_back", 32'(bus4.in_ready), 32'd1);
    chk("e4_pulse_width", 32'(bus4.out_valid), 32'd0);
    bus4.in_valid = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/smc_frame_loader.md
# smc_frame_loader

Sequential front/back end for the combinational SMC (6-transistor Id/gm sort-and-sum) stage. It collects one frame of six transistor parameter sets delivered serially, one per accepted beat, and presents them in parallel, with the frame's mode, to SMC. After a programmable settle window it registers SMC's `out_n` and emits it as a one-cycle result pulse. It sits directly upstream of SMC, driving every SMC input, and directly downstream of it, consuming `out_n`.

## Interface
Parameters:
- `EVAL_CYCLES`, default 1: cycles SMC inputs are held stable before `out_n` is sampled. Legal range 1..4.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: beat valid.
- `in_ready`, out, 1: loader can accept a beat.
- `mode_in`, in, 2: frame mode; sampled only on beat 0 of a frame.
- `w_in`, `vgs_in`, `vds_in`, in, 3 each: one transistor's W, V_GS, V_DS.
- `W_0`..`W_5`, `V_GS_0`..`V_GS_5`, `V_DS_0`..`V_DS_5`, out, 3 each: registered slots driven to SMC.
- `mode`, out, 2: registered frame mode driven to SMC.
- `smc_out`, in, 10: SMC `out_n`.
- `out_valid`, out, 1: result pulse.
- `out_data`, out, 10: registered result.

## Operation
- States: COLLECT, EVAL, DONE. Reset state is COLLECT with `cnt`=0 and `eval_cnt`=0.
- A beat is accepted when `in_valid && in_ready`.
- `in_ready` = 1 only in COLLECT. It is a combinational decode of the state register.
- COLLECT:
  - On acceptance, `w_in`/`vgs_in`/`vds_in` are written to slot `cnt`, and `cnt` increments.
  - If `cnt`==0 on acceptance, `mode_in` is also written to `mode`.
  - `in_valid` low stalls; `cnt` and the slots hold. There is no timeout.
  - Acceptance with `cnt`==5 moves to EVAL and clears `cnt` to 0.
- EVAL:
  - Slots and `mode` are frozen.
  - `eval_cnt` counts 0..`EVAL_CYCLES`-1.
  - On the edge ending the last EVAL cycle, `smc_out` is captured into `out_data` and the state moves to DONE.
- DONE:
  - `out_valid`=1 for exactly this one cycle, then the state returns to COLLECT.
  - No beat is accepted in DONE.
- `out_data` holds its value until the next capture. `out_valid` is 0 in every other state.
- Slots are not cleared between frames. Each new frame overwrites all six slots, in order.
- Inputs are unsigned 3-bit and pass through unmodified. No arithmetic is done here; all Id/gm/sort/sum math belongs to SMC.
- `mode_in` on beats 1..5 is ignored.

## Timing
- Reset (asynchronous, takes effect immediately, no clock needed):
  - `in_ready`=1 (COLLECT), `out_valid`=0, `out_data`=0.
  - All `W_*`/`V_GS_*`/`V_DS_*`=0, `mode`=0.
  - `cnt`=0, `eval_cnt`=0.
- Latency: the 6th beat is accepted on edge E. EVAL occupies cycles E..E+`EVAL_CYCLES`-1. `out_valid` is high in cycle E+`EVAL_CYCLES`. The next beat can be accepted at edge E+`EVAL_CYCLES`+1.
- Throughput with back-to-back beats: one frame per 6+`EVAL_CYCLES`+1 cycles (8 at the default).
- SMC inputs change only on accepted-beat edges. They are therefore stable for the whole EVAL window.
- Reset asserted mid-frame or mid-EVAL: the partial frame is discarded, no `out_valid` is produced, and the next frame starts at slot 0 with a fresh mode sample.
- Reset asserted during DONE: `out_valid` drops immediately.
- `in_valid` asserted during EVAL/DONE: ignored, since `in_ready`=0. The upstream source must hold the beat until it is accepted.

## Test plan
- Reset checks:
  - Assert `rst` asynchronously mid-cycle -> all outputs go to 0 and `in_ready` to 1 without a clock edge.
  - Release `rst` -> idle with no `out_valid`.
- Uniform frame, SMC instantiated:
  - `mode_in`=2'b11, six back-to-back beats of W=3, V_GS=3, V_DS=3 -> `out_valid` is high exactly 1 cycle after the 6th beat (`EVAL_CYCLES`=1) with `out_data`=48.
  - Repeat with `mode_in`=2'b00 -> `out_data`=12.
- Mixed frame with stalls:
  - `mode_in`=2'b10, beats: slots 0-2 W=7/V_GS=7/V_DS=1, slots 3-5 W=3/V_GS=3/V_DS=3, random `in_valid` gaps -> `out_data`=12 (gm 4,4,4 from slots 0-2).
  - Check slots match beat order and that `mode_in` toggled on beats 1..5 has no effect.
- Back-pressure:
  - Hold `in_valid`=1 continuously across 3 frames -> `in_ready` low for 2 cycles per frame.
  - Exactly 18 beats consumed; 3 `out_valid` pulses 8 cycles apart.
- Reset mid-frame:
  - Accept 4 beats, pulse `rst`, then send a full 6-beat frame with `mode_in`=2'b11 of W=3/V_GS=3/V_DS=3 -> single `out_valid`, `out_data`=48, with no pulse from the aborted frame.
- `EVAL_CYCLES`=4 build:
  - Same uniform frame -> `out_valid` occurs 4 cycles after the 6th beat.
  - `in_ready`=0 for 5 cycles.
  - SMC inputs unchanged throughout EVAL.
